// File: rtl/rr_arb_reg.sv
// Round-robin arbiter with a single registered output stage.
// N requesters compete with LSB-first rotating priority; the winner's payload is captured into a skid-free output register.
module rr_arb_reg #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req_vld,
  input  logic [N*W-1:0]       i_req_dat,
  output logic [N-1:0]         o_req_acc,
  output logic                 o_out_vld,
  output logic [W-1:0]         o_out_dat,
  output logic [$clog2(N)-1:0] o_out_id,
  input  logic                 i_out_rdy
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_dat_q, out_dat_d;
  logic [IW-1:0] out_id_q, out_id_d;

  logic [N-1:0]  masked;
  logic [IW-1:0] idx_masked, idx_any, sel_idx;
  logic          found_masked, found_any;
  logic [N-1:0]  sel_oh;
  logic [W-1:0]  sel_dat;
  logic          load;

  // Requests strictly above the last winner get first chance; ptr=N-1 masks nothing.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N; k++) begin
      masked[k] = i_req_vld[k] && (IW'(k) > ptr_q);
    end
  end

  always_comb begin
    idx_masked   = '0;
    idx_any      = '0;
    found_masked = 1'b0;
    found_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (masked[k] && !found_masked) begin
        found_masked = 1'b1;
        idx_masked   = IW'(k);
      end
      if (i_req_vld[k] && !found_any) begin
        found_any = 1'b1;
        idx_any   = IW'(k);
      end
    end
    sel_idx = found_masked ? idx_masked : idx_any;
    sel_oh  = found_any ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
  end

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == sel_idx) begin
        sel_dat = i_req_dat[k*W +: W];
      end
    end
  end

  // A drain and a refill in the same cycle collapse into one load, keeping full throughput.
  always_comb begin
    load      = (|i_req_vld) && (!out_vld_q || i_out_rdy);
    o_req_acc = (load && rst_n) ? sel_oh : '0;

    ptr_d     = ptr_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_id_d  = out_id_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_dat_d = sel_dat;
      out_id_d  = sel_idx;
      ptr_d     = sel_idx;
    end else if (out_vld_q && i_out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= IW'(N - 1);
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_id_q  <= out_id_d;
    end
  end

  assign o_out_vld = out_vld_q;
  assign o_out_dat = out_dat_q;
  assign o_out_id  = out_id_q;

endmodule

// File: tb/tb_rr_arb_reg.sv
// Testbench for rr_arb_reg: cycle model compared every cycle, directed literal checks,
// and a random run with a payload scoreboard and a starvation bound.
module tb_rr_arb_reg;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   i_req_vld;
  logic [N*W-1:0] i_req_dat;
  logic [N-1:0]   o_req_acc;
  logic           o_out_vld;
  logic [W-1:0]   o_out_dat;
  logic [1:0]     o_out_id;
  logic           i_out_rdy;

  int errors = 0;
  int checks = 0;

  rr_arb_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_vld (i_req_vld),
    .i_req_dat (i_req_dat),
    .o_req_acc (o_req_acc),
    .o_out_vld (o_out_vld),
    .o_out_dat (o_out_dat),
    .o_out_id  (o_out_id),
    .i_out_rdy (i_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change one time unit after the rising edge.
  task automatic applyStimulus(input logic rstn, input logic [N-1:0] vld, input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = rstn;
    i_req_vld = vld;
    i_out_rdy = rdy;
  endtask

  task automatic sampleOutputs();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] payload(input int k);
    return 32'hD00D_0000 + W'(k);
  endfunction

  // Behavioural model: rotating search starting just after the last winner.
  int           mLast;
  logic         mVld;
  logic [W-1:0] mDat;
  int           mId;
  bit           modelReady = 0;

  function automatic int pickRR(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last + off) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit modelLoad();
    return (i_req_vld != 0) && (!mVld || i_out_rdy);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mLast = N - 1;
      mVld  = 1'b0;
      mDat  = '0;
      mId   = 0;
      modelReady = 1;
    end else if (modelReady) begin
      if (modelLoad()) begin
        int g;
        g     = pickRR(i_req_vld, mLast);
        mLast = g;
        mVld  = 1'b1;
        mDat  = i_req_dat[g*W +: W];
        mId   = g;
      end else if (mVld && i_out_rdy) begin
        mVld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      logic [N-1:0] expAcc;
      expAcc = '0;
      if (rst_n && modelLoad()) expAcc[pickRR(i_req_vld, mLast)] = 1'b1;
      checkOutput("model_acc", 64'(o_req_acc), 64'(expAcc));
      checkOutput("model_vld", 64'(o_out_vld), 64'(mVld));
      checkOutput("model_dat", 64'(o_out_dat), 64'(mDat));
      checkOutput("model_id", 64'(o_out_id), 64'(mId));
      checkOutput("acc_onehot", 64'((o_req_acc & (o_req_acc - 1'b1)) == 0), 64'(1));
      checkOutput("acc_valid", 64'((o_req_acc & ~i_req_vld) == 0), 64'(1));
    end
  end

  logic [N-1:0] expAccSeq [5];
  int           expIdSeq  [5];
  logic [W-1:0] reqDat [N];
  logic [N-1:0] reqVld;
  logic [W-1:0] sbDat [$];
  int           sbId  [$];
  int           waitCnt [N];
  int           maxWait;

  initial begin
    rst_n     = 1'b0;
    i_req_vld = 4'b1111;
    i_out_rdy = 1'b1;
    for (int k = 0; k < N; k++) i_req_dat[k*W +: W] = payload(k);
    expAccSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expIdSeq  = '{0, 1, 2, 3, 0};

    // Reset with all requesting: no accepts, cleared outputs.
    applyStimulus(1'b0, 4'b1111, 1'b1);
    sampleOutputs();
    checkOutput("rst_acc", 64'(o_req_acc), 64'(0));
    checkOutput("rst_vld", 64'(o_out_vld), 64'(0));
    checkOutput("rst_dat", 64'(o_out_dat), 64'(0));
    checkOutput("rst_id", 64'(o_out_id), 64'(0));

    // Reset priority sequence.
    applyStimulus(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sampleOutputs();
      checkOutput("prio_acc", 64'(o_req_acc), 64'(expAccSeq[i]));
      if (i > 0) begin
        checkOutput("prio_vld", 64'(o_out_vld), 64'(1));
        checkOutput("prio_id", 64'(o_out_id), 64'(expIdSeq[i-1]));
        checkOutput("prio_dat", 64'(o_out_dat), 64'(payload(expIdSeq[i-1])));
      end
      if (i < 4) applyStimulus(1'b1, 4'b1111, 1'b1);
    end

    // Round-robin skip and wrap.
    applyStimulus(1'b1, 4'b0010, 1'b1);
    sampleOutputs();
    checkOutput("skip_pre_acc", 64'(o_req_acc), 64'(4'b0010));
    checkOutput("skip_pre_id", 64'(o_out_id), 64'(0));
    applyStimulus(1'b1, 4'b0101, 1'b1);
    sampleOutputs();
    checkOutput("skip_acc", 64'(o_req_acc), 64'(4'b0100));
    applyStimulus(1'b1, 4'b0101, 1'b1);
    sampleOutputs();
    checkOutput("wrap_acc", 64'(o_req_acc), 64'(4'b0001));
    checkOutput("wrap_id", 64'(o_out_id), 64'(2));

    // Backpressure: id 0 held five cycles while requester 1 waits.
    applyStimulus(1'b1, 4'b0010, 1'b0);
    for (int j = 0; j < 5; j++) begin
      sampleOutputs();
      checkOutput("bp_acc", 64'(o_req_acc), 64'(0));
      checkOutput("bp_vld", 64'(o_out_vld), 64'(1));
      checkOutput("bp_id", 64'(o_out_id), 64'(0));
      checkOutput("bp_dat", 64'(o_out_dat), 64'(payload(0)));
      applyStimulus(1'b1, 4'b0010, (j == 4) ? 1'b1 : 1'b0);
    end
    sampleOutputs();
    checkOutput("bp_release_acc", 64'(o_req_acc), 64'(4'b0010));

    // Drain without refill, then prove ptr stayed at 1 through the grant order.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    sampleOutputs();
    checkOutput("drain_pre_vld", 64'(o_out_vld), 64'(1));
    checkOutput("drain_pre_id", 64'(o_out_id), 64'(1));
    applyStimulus(1'b1, 4'b0000, 1'b1);
    sampleOutputs();
    checkOutput("drain_vld", 64'(o_out_vld), 64'(0));
    checkOutput("drain_id", 64'(o_out_id), 64'(1));
    applyStimulus(1'b1, 4'b0111, 1'b1);
    sampleOutputs();
    checkOutput("drain_ptr_acc", 64'(o_req_acc), 64'(4'b0100));

    // Reset while holding id 2.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    sampleOutputs();
    checkOutput("midrst_hold_id", 64'(o_out_id), 64'(2));
    checkOutput("midrst_hold_vld", 64'(o_out_vld), 64'(1));
    applyStimulus(1'b0, 4'b1000, 1'b0);
    sampleOutputs();
    checkOutput("midrst_acc", 64'(o_req_acc), 64'(0));
    applyStimulus(1'b1, 4'b1001, 1'b1);
    sampleOutputs();
    checkOutput("midrst_vld", 64'(o_out_vld), 64'(0));
    checkOutput("midrst_acc_after", 64'(o_req_acc), 64'(4'b0001));

    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);

    // Random run: requests held until accepted, random backpressure, then a drain tail.
    reqVld  = '0;
    maxWait = 0;
    for (int k = 0; k < N; k++) begin
      reqDat[k]  = '0;
      waitCnt[k] = 0;
    end
    for (int cyc = 0; cyc < 10020; cyc++) begin
      sampleOutputs();
      if (o_out_vld && i_out_rdy) begin
        if (sbDat.size() == 0) begin
          checkOutput("sb_underflow", 64'(1), 64'(0));
        end else begin
          checkOutput("sb_dat", 64'(o_out_dat), 64'(sbDat.pop_front()));
          checkOutput("sb_id", 64'(o_out_id), 64'(sbId.pop_front()));
        end
      end
      for (int k = 0; k < N; k++) begin
        if (o_req_acc[k]) begin
          sbDat.push_back(reqDat[k]);
          sbId.push_back(k);
          waitCnt[k] = 0;
        end else if (reqVld[k] && o_req_acc != 0) begin
          waitCnt[k]++;
          if (waitCnt[k] > maxWait) maxWait = waitCnt[k];
        end
      end
      for (int k = 0; k < N; k++) begin
        if (o_req_acc[k] || !reqVld[k]) begin
          reqVld[k] = (cyc < 10000) && ($urandom_range(0, 99) < 50);
          reqDat[k] = $urandom();
          if (!reqVld[k]) waitCnt[k] = 0;
        end
      end
      @(posedge clk);
      #1;
      i_req_vld = reqVld;
      for (int k = 0; k < N; k++) i_req_dat[k*W +: W] = reqDat[k];
      i_out_rdy = (cyc >= 10000) || ($urandom_range(0, 99) < 70);
    end
    sampleOutputs();
    checkOutput("rand_all_served", 64'(reqVld), 64'(0));
    checkOutput("rand_sb_empty", 64'(sbDat.size()), 64'(0));
    checkOutput("rand_max_wait_ok", 64'(maxWait <= N), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_reg.md
RR_ARB_REG -- requirements
Module: rr_arb_reg

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter W, default 32: payload width per requester, W >= 1.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port i_req_vld  input  N: per-requester valid, bit k = requester k.
REQ-006 SHALL have port i_req_dat  input  N*W: per-requester payload, requester k at bits [k*W +: W].
REQ-007 SHALL have port o_req_acc  output  N: one-hot-or-zero accept; bit k high = requester k transferred this cycle.
REQ-008 SHALL have port o_out_vld  output  1: registered output valid.
REQ-009 SHALL have port o_out_dat  output  W: registered payload of the winning requester.
REQ-010 SHALL have port o_out_id  output  $clog2(N): index of the requester that produced o_out_dat.
REQ-011 SHALL have port i_out_rdy  input  1: downstream ready.

Function
REQ-012 SHALL hold an internal pointer ptr of $clog2(N) bits, equal to the index of the last requester granted.
REQ-013 SHALL form masked requests as i_req_vld bits with index > ptr.
REQ-014 SHALL select the lowest-index masked request if any exists, else the lowest-index bit of i_req_vld (round-robin, LSB-first priority).
REQ-015 SHALL define load = (|i_req_vld) & (~o_out_vld | i_out_rdy), evaluated combinationally in the same cycle.
REQ-016 SHALL drive o_req_acc as the one-hot selected requester when load is high, and as all-zero otherwise; no path from o_req_acc back to i_req_vld is assumed.
REQ-017 SHALL, on a clock edge with load high, set o_out_vld=1, o_out_dat=payload of the selected requester, o_out_id=selected index, and ptr=selected index.
REQ-018 SHALL, on a clock edge with load low and o_out_vld & i_out_rdy high, set o_out_vld=0 and leave o_out_dat, o_out_id and ptr unchanged.
REQ-019 SHALL keep o_out_vld, o_out_dat and o_out_id stable while o_out_vld=1 and i_out_rdy=0.
REQ-020 SHALL treat a cycle with output drain (o_out_vld & i_out_rdy) and a pending request as a back-to-back transfer: load wins and o_out_vld stays 1; sustained throughput is one transfer per cycle.
REQ-021 SHALL have a latency of exactly one cycle from accept (o_req_acc bit high) to the payload appearing on o_out_dat with o_out_vld=1.
REQ-022 SHALL wrap ptr so that when ptr=N-1 no request is masked and selection restarts from index 0.
REQ-023 SHALL leave ptr unchanged in any cycle without load.
REQ-024 SHALL never assert more than one bit of o_req_acc, and SHALL never assert a bit whose i_req_vld is low.
REQ-025 SHALL require the upstream to hold i_req_vld and i_req_dat for requester k stable until o_req_acc[k] is high; the block does not buffer unaccepted requests.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, set o_out_vld=0, o_out_dat=0, o_out_id=0 and ptr=N-1, overriding any load or drain in that cycle.
REQ-027 SHALL drive o_req_acc=0 in every cycle with rst_n=0, so no requester observes a transfer during reset.
REQ-028 SHALL discard an output beat held when reset asserts mid-operation, and SHALL give requester 0 highest priority on the first grant after reset.

Verification
REQ-029 SHALL be verified for reset priority: N=4, after reset, i_req_vld=4'b1111, i_out_rdy=1 -> o_req_acc sequence 0001,0010,0100,1000,0001; o_out_id 0,1,2,3,0, one cycle later.
REQ-030 SHALL be verified for round-robin skip: ptr=1, i_req_vld=4'b0101 -> o_req_acc=0100; next cycle, with the same vld, o_req_acc=0001 (wrap).
REQ-031 SHALL be verified for backpressure: o_out_vld=1, i_out_rdy=0 for 5 cycles with i_req_vld=4'b0010 -> o_req_acc=0 and o_out_dat/o_out_id unchanged for all 5 cycles; on i_out_rdy=1, o_req_acc=0010 that cycle.
REQ-032 SHALL be verified for drain without refill: o_out_vld=1, i_out_rdy=1, i_req_vld=0 -> o_out_vld=0 next cycle; ptr unchanged, checked via the next grant order.
REQ-033 SHALL be verified for reset mid-operation: o_out_vld=1 holding id 2, rst_n=0 for one cycle with i_req_vld=4'b1000 -> o_req_acc=0, o_out_vld=0 after the edge, and the next grant with vld=4'b1001 goes to index 0.
REQ-034 SHALL be verified by a random-stimulus run (10k cycles) with checks that o_req_acc is one-hot-or-zero, no payload is lost or duplicated, and no requester waits more than N grants.
